sipo_frame_controller: RTL
==========================

# sipo_frame_controller

Sequencing controller for the serial-in/parallel-out shift-register datapath. Detects frame start, counts bit strobes, assembles a WIDTH-bit word LSB-first, and hands it off through a one-entry holding register with a valid/ready handshake. Sits between a bit-level serial source and any parallel consumer. Lets the next frame shift in while the previous word waits.

## Interface
- WIDTH, 4, data bits per frame; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- b  input  1  serial data bit, sampled only when bit_en=1
- bit_en  input  1  bit strobe; one data bit per cycle where bit_en=1
- sof  input  1  start of frame; qualified by bit_en; that cycle's b is bit 0
- out_data  output  WIDTH  assembled word; bit 0 = first received bit
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts word when out_valid=1
- busy  output  1  frame in progress (SHIFT or PARITY state)
- overrun  output  1  one-cycle pulse: completed word dropped, holding register full
- parity_err  output  1  parity status belonging to the word in out_data

## Operation
- Reset values: state=IDLE, bit counter=0, shift register=0, out_data=0, out_valid=0, busy=0, overrun=0, parity_err=0. Reset mid-frame discards the partial word and any held word.
- Shift: on each accepted bit, shift register shifts right; b enters MSB. After WIDTH accepted bits the first bit is in bit 0.
- States: IDLE, SHIFT, PARITY (PARITY present only with macro).
- IDLE: bit_en&sof -> capture bit 0, counter=1, go SHIFT. bit_en without sof ignored.
- SHIFT: bit_en&!sof -> shift, counter+1. bit_en&sof -> abort partial frame, capture as new bit 0, counter=1. On the WIDTH-th accepted bit: go PARITY (macro) or complete frame and go IDLE.
- Frame completion: if holding register empty, or out_valid&out_ready in the same cycle, load word into out_data and set out_valid next cycle; otherwise drop word, pulse overrun, keep held word unchanged.
- Handshake: transfer when out_valid&out_ready. out_data and parity_err stable while out_valid&!out_ready. out_valid clears after transfer unless a new word loads the same cycle (then stays 1, no overrun).
- out_ready while out_valid=0 has no effect.
- bit_en=0 cycles stall the frame indefinitely; no timeout.
- busy=1 exactly in SHIFT/PARITY.

## Timing
- Bit accepted on the rising edge where bit_en=1.
- Latency: edge accepting last data bit (no macro) or parity bit (macro) -> out_valid=1 after that same edge, i.e. visible the following cycle.
- Minimum frame: WIDTH consecutive bit_en cycles (WIDTH+1 with macro); back-to-back frames with no gap supported (sof on cycle after last bit).
- overrun asserted for exactly the cycle after the dropped completion.
- Throughput: one word per frame when consumer holds out_ready=1.

## Configuration
- PARITY_CHECK_EN defined: one extra bit follows the WIDTH data bits, accepted in PARITY state. Even parity: parity_err=XOR(data bits, parity bit); loaded with out_data, cleared on reset. sof in PARITY aborts and restarts as in SHIFT. Overrun rule applies at parity-bit completion.
- Not defined: no PARITY state, frame completes on WIDTH-th bit, parity_err tied 0.

## Test plan
- WIDTH=4, no macro: sof+bits 1,0,1,1 on 4 consecutive bit_en cycles, out_ready=1 -> out_data=4'hD, out_valid=1 for one cycle, busy 1 for 3 cycles after first edge.
- Hold out_ready=0; send frame 0xD then frame 0x3 -> out_data stays 0xD, overrun pulses once; raise out_ready -> 0xD transferred, out_valid=0.
- out_valid=1 with 0xD, second frame 0x6 completes in cycle with out_ready=1 -> out_valid stays 1, out_data=0x6, no overrun.
- sof reasserted after 2 bits, then bits 0,1,1,0 -> out_data=4'h6, partial frame discarded.
- rst asserted after 2 bits of a frame and while a word is held -> all outputs 0 immediately; next full frame 0xA delivered normally.
- PARITY_CHECK_EN: data 0xD plus parity 1 -> out_data=0xD, parity_err=0; parity 0 -> parity_err=1.

Source files
------------

// File: rtl/sipo_frame_controller_if.sv
// Serial-in / parallel-out frame controller bus.
// Bit source and word consumer signals grouped for one port.
interface sipo_frame_controller_if #(
  parameter int WIDTH = 4
);
  logic             b;
  logic             bit_en;
  logic             sof;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output b, bit_en, sof, out_ready,
    input  out_data, out_valid, busy,
    input  overrun, parity_err
  );

  modport slave (
    input  b, bit_en, sof, out_ready,
    output out_data, out_valid, busy,
    output overrun, parity_err
  );
endinterface

// File: rtl/sipo_frame_controller.sv
// LSB-first frame assembler with a one-entry output holding register.
// Define PARITY_CHECK_EN to add a trailing even-parity bit per frame.
module sipo_frame_controller #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sipo_frame_controller_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PARITY_CHECK_EN
    , PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             done;
  logic             accept;
  logic [WIDTH-1:0] word;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
  logic             perr_w;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done    = 1'b0;
    word    = sr_q;
`ifdef PARITY_CHECK_EN
    perr_w  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.bit_en && bus.sof) begin
          sr_d    = {bus.b, {(WIDTH-1){1'b0}}};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_en && bus.sof) begin
          // sof mid-frame drops the partial word
          sr_d  = {bus.b, {(WIDTH-1){1'b0}}};
          cnt_d = CW'(1);
        end else if (bus.bit_en) begin
          sr_d  = {bus.b, sr_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            done    = 1'b1;
            word    = {bus.b, sr_q[WIDTH-1:1]};
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bus.bit_en && bus.sof) begin
          sr_d    = {bus.b, {(WIDTH-1){1'b0}}};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end else if (bus.bit_en) begin
          done    = 1'b1;
          word    = sr_q;
          perr_w  = ^sr_q ^ bus.b;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // A full holding register still accepts if it drains this cycle
  assign accept = done && (!valid_q || bus.out_ready);

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = done && !accept;
    if (accept) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
`ifdef PARITY_CHECK_EN
    perr_d = accept ? perr_w : perr_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
